unpack6_ser_wn: RTL and testbench
=================================

UNPACK6_SER_WN -- requirements
Module: unpack6_ser_wn

Interface
REQ-001 SHALL have parameter: inwidth, default 1, lane width in bits (>=1).
REQ-002 SHALL have one clock; reset is synchronous and active-high.
REQ-003 SHALL have port: clk  input  1  rising-edge clock.
REQ-004 SHALL have port: reset  input  1  synchronous active-high reset.
REQ-005 SHALL have port: i_data  input  6*inwidth  packed word; lane k = bits [(k+1)*inwidth-1 : k*inwidth], lane 0 in the LSBs.
REQ-006 SHALL have port: i_valid  input  1  i_data valid.
REQ-007 SHALL have port: i_ready  output  1  block accepts i_data this cycle.
REQ-008 SHALL have port: o_data  output  inwidth  current lane.
REQ-009 SHALL have port: o_valid  output  1  o_data valid.
REQ-010 SHALL have port: o_ready  input  1  consumer accepts o_data.
REQ-011 SHALL have port: o_idx  output  3  index (0..5) of the lane on o_data.
REQ-012 SHALL have port: o_last  output  1  high with o_valid on the final lane of a word.

Function
REQ-013 SHALL implement two states: IDLE (no word held) and SEND (word held, lanes emitting).
REQ-014 SHALL transfer input when i_valid && i_ready and output when o_valid && o_ready.
REQ-015 SHALL drive i_ready = (IDLE) || (SEND && o_ready && o_last), and 0 while reset is high.
REQ-016 IDLE: on input transfer, SHALL capture i_data and enter SEND with o_idx=0; lane 0 appears on o_data the next cycle (1-cycle latency).
REQ-017 SEND: o_valid=1, o_data=held lane[o_idx]; o_data/o_idx SHALL stay stable while o_ready=0.
REQ-018 SEND, output transfer with o_idx<last: o_idx SHALL increment by 1 next cycle.
REQ-019 SEND, output transfer on last lane, no input transfer: SHALL return to IDLE, o_valid=0 next cycle.
REQ-020 SEND, output transfer on last lane with simultaneous input transfer: SHALL capture the new word, stay in SEND, o_idx=0 next cycle (zero bubble; one lane per cycle sustained).
REQ-021 SHALL ignore i_data/i_valid whenever i_ready=0; a word is never dropped or duplicated.
REQ-022 last lane index SHALL be 5 unless REQ-026 applies.

Reset
REQ-023 While reset is high at a clk edge: state=IDLE, o_valid=0, o_data=0, o_idx=0, o_last=0, held word cleared.
REQ-024 Reset mid-word SHALL discard remaining lanes; no lane is emitted after reset.

Configuration
REQ-025 Macro UNPACK6_CNT_EN SHALL select variable lane count.
REQ-026 With UNPACK6_CNT_EN: extra port i_cnt input 3, captured with i_data; lanes 0..i_cnt-1 emitted; i_cnt=0 or >6 treated as 6.
REQ-027 Without UNPACK6_CNT_EN: no i_cnt port; always 6 lanes.

Structure
REQ-028 Package unpack6_pkg SHALL hold NLANES=6, state enum (IDLE, SEND), 3-bit lane-index type.
REQ-029 Lane selection SHALL be one sub-module unpack6_lane_mux (packed word + index -> lane), combinational; all state in the top.

Verification
REQ-030 inwidth=8, i_data=0x060504030201 once, o_ready=1 -> o_data 01,02,03,04,05,06 on six consecutive cycles, o_last only with 06, then o_valid=0.
REQ-031 Two words back-to-back, o_ready=1 -> 12 consecutive valid lanes, no bubble, i_ready high only in IDLE cycle and the cycle of each last lane.
REQ-032 o_ready toggling 1,0,0,1,... -> o_data/o_idx held during stalls, order 01..06 preserved, no lane lost.
REQ-033 reset asserted after lane 2 transfer -> next cycle o_valid=0, o_idx=0, i_ready=1 after reset release; following word starts at lane 0.
REQ-034 UNPACK6_CNT_EN, i_cnt=3 then i_cnt=0 -> first word emits 3 lanes (o_last on idx 2), second emits 6 lanes.

Source files
------------

// File: rtl/unpack6_pkg.sv
// unpack6_pkg: shared constants and types for the 6-lane word serialiser.
//   NLANES     - number of lanes in a packed word
//   state_t    - serialiser state (IDLE: no word held, SEND: lanes emitting)
//   lane_idx_t - 3-bit lane index
package unpack6_pkg;
   localparam int NLANES = 6;
   typedef enum logic {IDLE, SEND} state_t;
   typedef logic [2:0] lane_idx_t;
endpackage

// File: rtl/unpack6_lane_mux.sv
// unpack6_lane_mux: combinational lane selector for a packed 6-lane word.
//   word (in)  - packed word, lane k at bits [(k+1)*inwidth-1 : k*inwidth]
//   idx  (in)  - lane index 0..5
//   lane (out) - selected lane; zero for out-of-range indices
module unpack6_lane_mux
   import unpack6_pkg::*;
#(
   parameter int inwidth = 1
) (
   input  logic [NLANES*inwidth-1:0] word,
   input  lane_idx_t                 idx,
   output logic [inwidth-1:0]        lane
);
   assign lane = (int'(idx) < NLANES) ? word[int'(idx)*inwidth +: inwidth] : '0;
endmodule

// File: rtl/unpack6_ser_wn.sv
// unpack6_ser_wn: captures a 6-lane packed word and emits it one lane per cycle.
//   clk, reset       - rising-edge clock, synchronous active-high reset
//   i_data/i_valid   - packed input word and its valid; i_ready accepts it
//   o_data/o_valid   - current lane and its valid; o_ready accepts it
//   o_idx, o_last    - index of the lane on o_data, final-lane flag
//   i_cnt            - lane count captured with i_data (0 or >6 means 6),
//                      present only when UNPACK6_CNT_EN is defined
// A new word is accepted in the same cycle the final lane leaves, so
// back-to-back words stream with no bubble.
module unpack6_ser_wn
   import unpack6_pkg::*;
#(
   parameter int inwidth = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NLANES*inwidth-1:0] i_data,
   input  logic                     i_valid,
   output logic                     i_ready,
   output logic [inwidth-1:0]       o_data,
   output logic                     o_valid,
   input  logic                     o_ready,
   output lane_idx_t                o_idx,
   output logic                     o_last
`ifdef UNPACK6_CNT_EN
   ,
   input  logic [2:0]               i_cnt
`endif
);
   state_t                    state_q, state_d;
   logic [NLANES*inwidth-1:0] word_q, word_d;
   lane_idx_t                 idx_q, idx_d, last_q, last_d, cnt_last;
   logic                      in_xfer, out_xfer;
`ifdef UNPACK6_CNT_EN
   assign cnt_last = (i_cnt == 3'd0 || i_cnt > 3'(NLANES)) ? lane_idx_t'(NLANES - 1) : i_cnt - 3'd1;
`else
   assign cnt_last = lane_idx_t'(NLANES - 1);
`endif
   assign o_valid  = state_q == SEND;
   assign o_idx    = idx_q;
   assign o_last   = o_valid && idx_q == last_q;
   assign i_ready  = !reset && (!o_valid || (o_ready && o_last));
   assign in_xfer  = i_valid && i_ready;
   assign out_xfer = o_valid && o_ready;
   always_comb begin
      state_d = in_xfer ? SEND : (out_xfer && o_last) ? IDLE : state_q;
      word_d  = in_xfer ? i_data : word_q;
      last_d  = in_xfer ? cnt_last : last_q;
      idx_d   = in_xfer ? '0 : (out_xfer && !o_last) ? idx_q + 3'd1 : idx_q;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         word_q  <= '0;
         idx_q   <= '0;
         last_q  <= '0;
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
         idx_q   <= idx_d;
         last_q  <= last_d;
      end
   end
   unpack6_lane_mux #(.inwidth(inwidth)) u_mux (
      .word (word_q),
      .idx  (idx_q),
      .lane (o_data)
   );
endmodule

// File: tb/tb_unpack6_ser_wn.sv
// tb_unpack6_ser_wn: scoreboard bench for unpack6_ser_wn with 8-bit lanes.
module tb_unpack6_ser_wn;
   localparam int W = 8;
   typedef struct {logic [6*W-1:0] data; logic [2:0] cnt; int n;} word_t;
   typedef struct {logic [W-1:0] d; logic [2:0] idx; logic last;} lane_t;
   logic           clk = 0, reset = 1, i_valid = 0, o_ready = 1, acc = 0;
   logic [6*W-1:0] i_data = '0;
   logic           i_ready, o_valid, o_last;
   logic [W-1:0]   o_data;
   logic [2:0]     o_idx;
`ifdef UNPACK6_CNT_EN
   logic [2:0]     i_cnt = '0;
`endif
   word_t wq[$];
   lane_t sb[$];
   int    checks = 0, failures = 0, pops = 0, cyc = 0, first_pop = -1, last_pop = -1;
   bit    stall_mode = 0;

   unpack6_ser_wn #(.inwidth(W)) dut (
      .clk(clk), .reset(reset), .i_data(i_data), .i_valid(i_valid), .i_ready(i_ready),
      .o_data(o_data), .o_valid(o_valid), .o_ready(o_ready), .o_idx(o_idx), .o_last(o_last)
`ifdef UNPACK6_CNT_EN
      , .i_cnt(i_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic push(logic [6*W-1:0] d, logic [2:0] c, int n);
      word_t w;
      w.data = d;
      w.cnt  = c;
      w.n    = n;
      wq.push_back(w);
   endtask

   task automatic wait_done(string name);
      int n = 0;
      while ((sb.size() != 0 || wq.size() != 0) && n < 300) begin
         @(negedge clk); #1;
         n++;
      end
      if (n >= 300) begin
         checks++;
         failures++;
         $display("FAIL %s timeout pending_lanes=%0d pending_words=%0d", name, sb.size(), wq.size());
      end
      @(negedge clk); #1;
      chk({name, "_idle_valid"}, o_valid, 0);
   endtask

   // driver: offers queued words, records accepted ones as expected lanes
   initial forever begin
      word_t w;
      @(posedge clk);
      cyc++;
      if (acc && wq.size() != 0) begin
         w = wq.pop_front();
         for (int k = 0; k < w.n; k++) begin
            lane_t l;
            l.d    = w.data[k*W +: W];
            l.idx  = 3'(k);
            l.last = (k == w.n - 1);
            sb.push_back(l);
         end
      end
      #1;
      o_ready = stall_mode ? (cyc % 3 == 0) : 1'b1;
      i_valid = wq.size() != 0;
      if (wq.size() != 0) begin
         i_data = wq[0].data;
`ifdef UNPACK6_CNT_EN
         i_cnt = wq[0].cnt;
`endif
      end
   end

   always @(negedge clk) acc = i_valid && i_ready;

   // monitor: every valid cycle must present the scoreboard head
   always @(negedge clk) begin
      if (!reset) begin
         if (o_valid) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_lane actual=idx%0d data=%0h required=no_lane", o_idx, o_data);
            end else begin
               chk("lane_data", o_data, sb[0].d);
               chk("lane_idx", o_idx, sb[0].idx);
               chk("lane_last", o_last, sb[0].last);
               chk("busy_ready", i_ready, o_ready && sb[0].last);
               if (o_ready) begin
                  void'(sb.pop_front());
                  pops++;
                  if (first_pop < 0) first_pop = cyc;
                  last_pop = cyc;
               end
            end
         end else begin
            chk("idle_ready", i_ready, 1);
            chk("idle_last", o_last, 0);
         end
      end
   end

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", o_valid, 0);
      chk("rst_data", o_data, 0);
      chk("rst_idx", o_idx, 0);
      chk("rst_last", o_last, 0);
      chk("rst_ready", i_ready, 0);
      @(posedge clk); #1 reset = 0;
      @(negedge clk);
      chk("ready_after_rst", i_ready, 1);
      // single word, free-flowing output
      first_pop = -1;
      push(48'h060504030201, 3'd0, 6);
      wait_done("single");
      chk("single_pops", pops, 6);
      chk("single_span", last_pop - first_pop, 5);
      // two words back-to-back
      first_pop = -1;
      push(48'hA6A5A4A3A2A1, 3'd0, 6);
      push(48'hB6B5B4B3B2B1, 3'd0, 6);
      wait_done("b2b");
      chk("b2b_pops", pops, 18);
      chk("b2b_span", last_pop - first_pop, 11);
      // consumer stalls
      stall_mode = 1;
      push(48'h060504030201, 3'd0, 6);
      wait_done("stall");
      stall_mode = 0;
      chk("stall_pops", pops, 24);
      // reset after lane 2 has transferred
      push(48'h161514131211, 3'd0, 6);
      for (int n = 0; n < 100 && pops < 27; n++) begin
         @(negedge clk); #1;
      end
      chk("pre_rst_pops", pops, 27);
      @(posedge clk); #1 reset = 1;
      sb.delete();
      wq.delete();
      @(negedge clk);
      @(negedge clk);
      chk("mid_rst_valid", o_valid, 0);
      chk("mid_rst_idx", o_idx, 0);
      chk("mid_rst_data", o_data, 0);
      chk("mid_rst_last", o_last, 0);
      @(posedge clk); #1 reset = 0;
      @(negedge clk);
      chk("post_rst_ready", i_ready, 1);
      push(48'h262524232221, 3'd0, 6);
      wait_done("post_rst");
      chk("post_rst_pops", pops, 33);
`ifdef UNPACK6_CNT_EN
      push(48'h363534333231, 3'd3, 3);
      push(48'h464544434241, 3'd0, 6);
      push(48'h565554535251, 3'd7, 6);
      push(48'h666564636261, 3'd1, 1);
      wait_done("cnt");
      chk("cnt_pops", pops, 49);
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end
endmodule
